uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: UartTxArbiter

---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds whole packets from N byte-stream requesters into one UART transmitter.
// A grant stays locked to one requester until its last byte is sent or, optionally, until it stalls too long.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N-1:0]       req_din,
    input  logic [N-1:0]         req_valid,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic [7:0]           tx_din,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid
);

    localparam int GW = $clog2(N);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t         state;
    logic [GW-1:0]  ptr;
    logic [GW-1:0]  pick;
    logic [CW-1:0]  idle_cnt;
    logic           last_q;
    logic           xfer;
    logic [7:0]     din_arr [N];

    always_comb begin
        for (int i = 0; i < N; i++) din_arr[i] = req_din[8*i +: 8];
    end

    // Scan from the farthest candidate back to ptr+1 so the nearest requester above ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        pick = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_valid[(int'(ptr) + k) % N]) pick = GW'((int'(ptr) + k) % N);
        end
    end

    // Ready depends only on registered state and tx_busy, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state == GRANT && !tx_busy) req_ready[grant_id] = 1'b1;
    end

    assign xfer        = (state == GRANT) && req_valid[grant_id] && !tx_busy;
    assign grant_valid = (state != IDLE);

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state    <= IDLE;
            ptr      <= GW'(N - 1);
            grant_id <= '0;
            idle_cnt <= '0;
            last_q   <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        tx_din   <= din_arr[grant_id];
                        tx_start <= 1'b1;
                        last_q   <= req_last[grant_id];
                        idle_cnt <= '0;
                        state    <= WAIT_BUSY;
                    end else if (TIMEOUT > 0 && !req_valid[grant_id]) begin
                        if (idle_cnt == CW'(TIMEOUT - 1)) begin
                            idle_cnt <= '0;
                            ptr      <= grant_id;
                            state    <= IDLE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // Non-final bytes return to GRANT with the same holder: the packet lock.
                    if (!tx_busy) begin
                        if (last_q) begin
                            ptr   <= grant_id;
                            state <= IDLE;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter driving a behavioural UART transmitter (BR_DIV=108, 8N1)
// plus a serial-line decoder that rebuilds the byte stream actually sent.
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int BR_DIV = 108;
    localparam int LIMIT  = 3000;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] exp_gid;
        logic [7:0] exp_byte;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     din [N];
    logic [8*N-1:0] req_din;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last  = '1;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_din;
    logic           tx_start;
    logic           tx_busy;
    logic           uart_busy;
    logic           busy_force = 1'b0;
    logic [1:0]     grant_id;
    logic           grant_valid;

    logic [N-1:0]   nt_valid = '0;
    logic [N-1:0]   nt_ready;
    logic [7:0]     nt_tx_din;
    logic           nt_start;
    logic [1:0]     nt_gid;
    logic           nt_gv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign req_din = {din[3], din[2], din[1], din[0]};
    assign tx_busy = uart_busy | busy_force;

    uart_tx_arbiter #(.N(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_din(req_din), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .tx_din(tx_din), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .grant_valid(grant_valid)
    );

    uart_tx_arbiter #(.N(N), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .req_din(32'h44332211), .req_valid(nt_valid), .req_last(4'hF),
        .req_ready(nt_ready), .tx_din(nt_tx_din), .tx_start(nt_start), .tx_busy(1'b0),
        .grant_id(nt_gid), .grant_valid(nt_gv)
    );

    // UART transmitter model: start bit, 8 data bits LSB first, stop bit.
    logic [9:0] sh;
    int         div, bitn;
    logic       line;
    assign line = sh[0];

    always @(posedge clk) begin
        if (rst) begin
            uart_busy <= 1'b0; sh <= '1; div <= 0; bitn <= 0;
        end else if (!uart_busy) begin
            if (tx_start) begin
                sh <= {1'b1, tx_din, 1'b0}; uart_busy <= 1'b1; div <= 0; bitn <= 0;
            end
        end else if (div == BR_DIV - 1) begin
            div <= 0;
            sh  <= {1'b1, sh[9:1]};
            if (bitn == 9) uart_busy <= 1'b0;
            else bitn <= bitn + 1;
        end else begin
            div <= div + 1;
        end
    end

    // Serial decoder sampling mid-bit.
    logic [7:0] rx_sh;
    int         rx_cnt, rx_bit;
    bit         rx_act;
    logic [7:0] rx_q [$];

    always @(posedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (!line) begin rx_act <= 1'b1; rx_cnt <= 0; rx_bit <= 0; end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == BR_DIV/2 + BR_DIV*(rx_bit + 1)) begin
                if (rx_bit < 8) begin
                    rx_sh  <= {line, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1;
                end else begin
                    rx_q.push_back(rx_sh);
                    rx_act <= 1'b0;
                end
            end
        end
    end

    // Running invariant counters.
    int   start_cnt   = 0;
    int   multi_ready = 0;
    int   r2_g0       = 0;
    int   dbl_start   = 0;
    logic prev_start  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(req_ready) > 1) multi_ready <= multi_ready + 1;
            if (grant_id == 2'd0 && req_ready[2]) r2_g0 <= r2_g0 + 1;
            if (tx_start) start_cnt <= start_cnt + 1;
            if (tx_start && prev_start) dbl_start <= dbl_start + 1;
        end
        prev_start <= tx_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; nt_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns just after the edge on which a transfer happened.
    task automatic wait_xfer(output int gid);
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                gid = int'(grant_id);
                @(posedge clk); #1;
                return;
            end
        end
        gid = -1;
        checks++; failures++;
        $display("FAIL xfer_timeout: no transfer within %0d cycles", LIMIT);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (!grant_valid) return;
        end
        checks++; failures++;
        $display("FAIL idle_timeout: grant_valid still %0b after %0d cycles", grant_valid, LIMIT);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp [], input int n);
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++)
            if (rx_q.size() > i) check($sformatf("%s_byte%0d", name, i), rx_q[i], exp[i]);
    endtask

    vec_t tbl [11];
    int   g, s0, cnt;

    initial begin
        tbl[0]  = '{4'b1111, 2'd0, 8'hC0};
        tbl[1]  = '{4'b1111, 2'd1, 8'hC1};
        tbl[2]  = '{4'b1111, 2'd2, 8'hC2};
        tbl[3]  = '{4'b1111, 2'd3, 8'hC3};
        tbl[4]  = '{4'b1111, 2'd0, 8'hC0};
        tbl[5]  = '{4'b1111, 2'd1, 8'hC1};
        tbl[6]  = '{4'b0001, 2'd0, 8'hC0};
        tbl[7]  = '{4'b1000, 2'd3, 8'hC3};
        tbl[8]  = '{4'b0110, 2'd1, 8'hC1};
        tbl[9]  = '{4'b0011, 2'd0, 8'hC0};
        tbl[10] = '{4'b1001, 2'd3, 8'hC3};
        for (int i = 0; i < N; i++) din[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);

        // Single byte from requester 0, then ptr=0 shown by 0101 going to requester 2
        @(posedge clk); #1;
        rx_q.delete();
        s0 = start_cnt;
        din[0] = 8'hA5; req_last = '1; req_valid = 4'b0001;
        wait_xfer(g);
        req_valid = '0;
        check("s1_gid", g, 0);
        check("s1_tx_start", tx_start, 1);
        check("s1_tx_din", tx_din, 8'hA5);
        wait_idle();
        check("s1_start_count", start_cnt - s0, 1);
        check_rx("s1_rx", '{8'hA5}, 1);
        req_valid = 4'b0101;
        wait_xfer(g);
        req_valid = '0;
        check("s1_ptr_after", g, 2);
        wait_idle();

        // Round-robin table
        do_reset();
        rx_q.delete();
        for (int i = 0; i < N; i++) din[i] = 8'hC0 + 8'(i);
        req_last  = '1;
        req_valid = tbl[0].mask;
        for (int r = 0; r < 11; r++) begin
            wait_xfer(g);
            req_valid = (r + 1 < 11) ? tbl[r+1].mask : 4'b0000;
            check($sformatf("rr_gid%0d", r), g, tbl[r].exp_gid);
        end
        wait_idle();
        check("rr_rx_count", rx_q.size(), 11);
        for (int r = 0; r < 11; r++)
            if (rx_q.size() > r) check($sformatf("rr_rx%0d", r), rx_q[r], tbl[r].exp_byte);
        check("rr_onehot_ready", multi_ready, 0);
        check("rr_double_start", dbl_start, 0);

        // Two 2-byte packets: packet lock keeps requester 2 out
        do_reset();
        rx_q.delete();
        s0 = r2_g0;
        din[0] = 8'h11; din[2] = 8'h21; req_last = 4'b1010; req_valid = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_xfer(g);
            case (j)
                0: begin din[0] = 8'h12; req_last[0] = 1'b1; end
                1: req_valid[0] = 1'b0;
                2: begin din[2] = 8'h22; req_last[2] = 1'b1; end
                default: req_valid[2] = 1'b0;
            endcase
            check($sformatf("pk_gid%0d", j), g, (j < 2) ? 0 : 2);
        end
        wait_idle();
        check_rx("pk_rx", '{8'h11, 8'h12, 8'h21, 8'h22}, 4);
        check("pk_r2_while_g0", r2_g0 - s0, 0);

        // Timeout: requester 1 stalls mid-packet, grant moves to 3 after 16 GRANT cycles
        do_reset();
        rx_q.delete();
        din[1] = 8'h55; din[3] = 8'h77; req_last = 4'b1101; req_valid = 4'b1010;
        wait_xfer(g);
        req_valid[1] = 1'b0;
        check("to_first_gid", g, 1);
        cnt = 0; g = -1;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (req_ready[1]) cnt++;
            if ((req_valid & req_ready) != '0) begin g = int'(grant_id); break; end
        end
        check("to_grant_cycles", cnt, 16);
        check("to_next_gid", g, 3);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();
        check_rx("to_rx", '{8'h55, 8'h77}, 2);

        // tx_busy held high externally while in GRANT
        do_reset();
        busy_force = 1'b1;
        din[0] = 8'h3C; req_last = '1; req_valid = 4'b0001;
        s0 = start_cnt; cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (req_ready != '0) cnt++;
        end
        check("busy_ready_cycles", cnt, 0);
        check("busy_no_start", start_cnt - s0, 0);
        check("busy_grant_valid", grant_valid, 1);
        busy_force = 1'b0;
        wait_xfer(g);
        req_valid = '0;
        check("busy_gid", g, 0);
        check("busy_tx_start", tx_start, 1);
        check("busy_tx_din", tx_din, 8'h3C);
        wait_idle();

        // Reset during WAIT_DONE of a 3-byte packet
        do_reset();
        din[1] = 8'hA1; req_last = 4'b1101; req_valid = 4'b0010;
        wait_xfer(g);
        din[1] = 8'hA2;
        wait_xfer(g);
        din[1] = 8'hA3; req_last[1] = 1'b1;
        for (int c = 0; c < 20 && !tx_busy; c++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("mid_in_wait_done", tx_busy && grant_valid && req_ready == '0, 1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        s0 = start_cnt;
        @(negedge clk);
        check("mid_tx_start", tx_start, 0);
        check("mid_req_ready", req_ready, 0);
        check("mid_grant_valid", grant_valid, 0);
        check("mid_tx_din", tx_din, 0);
        check("mid_grant_id", grant_id, 0);
        din[0] = 8'hB0; req_last = '1; req_valid = 4'b0011;
        wait_xfer(g);
        req_valid = '0;
        check("mid_no_stray_start", start_cnt - s0, 0);
        check("mid_next_gid", g, 0);
        wait_idle();

        // TIMEOUT=0: GRANT is held indefinitely, earliest transfer one cycle after IDLE
        do_reset();
        nt_valid = 4'b0001;
        @(posedge clk); #1;
        nt_valid = '0;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (nt_ready[0]) cnt++;
        end
        check("nt_hold_cycles", cnt, 100);
        check("nt_grant_valid", nt_gv, 1);
        nt_valid = 4'b0001;
        @(posedge clk); #1;
        nt_valid = '0;
        check("nt_tx_start", nt_start, 1);
        check("nt_tx_din", nt_tx_din, 8'h11);
        @(posedge clk); #1;
        check("nt_start_one_cycle", nt_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
